// File: rtl/switch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// switch_sequencer_pkg
//   Shared types and constants for the switch sequencer front-end.
//   - seq_state_t     : sequencer FSM state encoding
//   - DEF_DB_CYCLES   : default debounce stability window (clocks)
//   - DEF_GO_BIT      : default index of the load/go/show control switch
//   - HALT_PC         : cpu program-counter value that signals halt
// -----------------------------------------------------------------------------
package switch_sequencer_pkg;

    localparam int         DEF_N         = 8;
    localparam int         DEF_SW_W      = 10;
    localparam int         DEF_DB_CYCLES = 16;
    localparam int         DEF_GO_BIT    = 8;
    localparam logic [7:0] HALT_PC       = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_X_LOADED = 3'd1,
        ST_Y_LOADED = 3'd2,
        ST_RUN      = 3'd3,
        ST_SHOW_X   = 3'd4,
        ST_SHOW_Y   = 3'd5,
        ST_ERROR    = 3'd6
    } seq_state_t;

endpackage

// File: rtl/switch_sequencer_if.sv
// -----------------------------------------------------------------------------
// switch_sequencer_if
//   Bundle between the board/cpu side and the switch sequencer.
//   Signals:
//     Switches   : raw asynchronous switch levels        (board -> sequencer)
//     Halted     : cpu halt level                        (cpu   -> sequencer)
//     Operand    : latched debounced Switches[n-1:0]     (sequencer -> cpu)
//     LoadX      : one-cycle strobe, Operand is X
//     LoadY      : one-cycle strobe, Operand is Y
//     Start      : one-cycle strobe, begin execution
//     ShowSel    : 0 = show result/X, 1 = show Y
//     Busy       : high while the cpu runs
//     Error      : RUN watchdog expired
//     DbSwitches : debounced switch levels
//   Modports: master = board/cpu side, slave = sequencer.
// -----------------------------------------------------------------------------
interface switch_sequencer_if
    import switch_sequencer_pkg::*;
#(
    parameter int n    = DEF_N,
    parameter int SW_W = DEF_SW_W
);
    logic [SW_W-1:0] Switches;
    logic            Halted;
    logic [n-1:0]    Operand;
    logic            LoadX;
    logic            LoadY;
    logic            Start;
    logic            ShowSel;
    logic            Busy;
    logic            Error;
    logic [SW_W-1:0] DbSwitches;

    modport master (
        output Switches, Halted,
        input  Operand, LoadX, LoadY, Start, ShowSel, Busy, Error, DbSwitches
    );

    modport slave (
        input  Switches, Halted,
        output Operand, LoadX, LoadY, Start, ShowSel, Busy, Error, DbSwitches
    );

endinterface

// File: rtl/switch_sequencer_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//   Single-bit 2-flop synchroniser followed by a stability counter.
//   The debounced level toggles once the synchronised input has differed from
//   it for DB_CYCLES consecutive clocks; any shorter excursion is discarded.
//   Raw-to-output latency is 2 + DB_CYCLES clocks.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : asynchronous active-high reset
//     raw_i  : raw asynchronous input
//     db_o   : debounced level
// -----------------------------------------------------------------------------
module switch_debounce
    import switch_sequencer_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic db_o
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Toggle on the clock that would take the count to DB_CYCLES, so the stored
    // count never exceeds DB_CYCLES-1 and cannot wrap.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/switch_sequencer.sv
// -----------------------------------------------------------------------------
// switch_sequencer
//   Front-end between board switches and the cpu. Debounces every switch,
//   edge-detects the control switch at GO_BIT and runs the operand handshake:
//   load X, load Y, go, show result, show Y, back to idle.
//   Ports:
//     Clock : system clock, rising edge
//     Reset : asynchronous active-high reset
//     bus   : switch_sequencer_if.slave (Switches/Halted in; Operand, LoadX,
//             LoadY, Start, ShowSel, Busy, Error, DbSwitches out)
//   Optional feature (macro SWITCH_SEQUENCER_TIMEOUT_EN): RUN watchdog of
//   TIMEOUT_CYCLES clocks leading to an ERROR state that is left by a rise then
//   a fall of the control switch. Without it Error is tied 0.
// -----------------------------------------------------------------------------
module switch_sequencer
    import switch_sequencer_pkg::*;
#(
    parameter int n              = DEF_N,
    parameter int SW_W           = DEF_SW_W,
    parameter int GO_BIT         = DEF_GO_BIT,
    parameter int DB_CYCLES      = DEF_DB_CYCLES,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic               Clock,
    input logic               Reset,
    switch_sequencer_if.slave bus
);

    logic [SW_W-1:0] db;

    for (genvar i = 0; i < SW_W; i++) begin : g_db
        switch_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i(Clock),
            .rst_i(Reset),
            .raw_i(bus.Switches[i]),
            .db_o (db[i])
        );
    end

    assign bus.DbSwitches = db;

    // Control switch edge detect: each edge is valid for exactly one cycle.
    logic go_q;
    logic rise, fall;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) go_q <= 1'b0;
        else       go_q <= db[GO_BIT];
    end

    assign rise =  db[GO_BIT] & ~go_q;
    assign fall = ~db[GO_BIT] &  go_q;

    seq_state_t   state_q, state_d;
    logic [n-1:0] operand_q, operand_d;
    logic         loadx_q, loadx_d;
    logic         loady_q, loady_d;
    logic         start_q, start_d;
    logic         showsel_q, showsel_d;

`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
    localparam int RUN_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 err_arm_q, err_arm_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        loadx_d   = 1'b0;
        loady_d   = 1'b0;
        start_d   = 1'b0;
        showsel_d = showsel_q;
`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
        run_cnt_d = run_cnt_q;
        err_arm_d = err_arm_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    operand_d = db[n-1:0];
                    loadx_d   = 1'b1;
                    state_d   = ST_X_LOADED;
                end
            end
            ST_X_LOADED: begin
                if (rise) begin
                    operand_d = db[n-1:0];
                    loady_d   = 1'b1;
                    state_d   = ST_Y_LOADED;
                end
            end
            ST_Y_LOADED: begin
                if (fall) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
                    run_cnt_d = '0;
`endif
                end
            end
            ST_RUN: begin
                // Halted is checked first so it wins over a same-cycle timeout.
                if (bus.Halted) begin
                    state_d   = ST_SHOW_X;
                    showsel_d = 1'b0;
                end
`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
                // Count value k is held during the (k+1)th RUN cycle, so
                // matching TIMEOUT_CYCLES-1 lands Error TIMEOUT_CYCLES clocks
                // after Start.
                else if (run_cnt_q == RUN_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_ERROR;
                    err_arm_d = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                end
`endif
            end
            ST_SHOW_X: begin
                if (rise) begin
                    state_d   = ST_SHOW_Y;
                    showsel_d = 1'b1;
                end
            end
            ST_SHOW_Y: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    showsel_d = 1'b0;
                end
            end
`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
            ST_ERROR: begin
                // A fall only releases the error after a rise seen here.
                if (rise) begin
                    err_arm_d = 1'b1;
                end else if (fall && err_arm_q) begin
                    err_arm_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            loadx_q   <= 1'b0;
            loady_q   <= 1'b0;
            start_q   <= 1'b0;
            showsel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            loadx_q   <= loadx_d;
            loady_q   <= loady_d;
            start_q   <= start_d;
            showsel_q <= showsel_d;
        end
    end

`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            run_cnt_q <= '0;
            err_arm_q <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            err_arm_q <= err_arm_d;
        end
    end

    assign bus.Error = (state_q == ST_ERROR);
`else
    assign bus.Error = 1'b0;
`endif

    assign bus.Operand = operand_q;
    assign bus.LoadX   = loadx_q;
    assign bus.LoadY   = loady_q;
    assign bus.Start   = start_q;
    assign bus.ShowSel = showsel_q;
    assign bus.Busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_switch_sequencer
//   Self-checking bench for switch_sequencer (DB_CYCLES=4, TIMEOUT_CYCLES=100).
//   Strobe expectations are queued when the control switch is driven and
//   popped by a monitor when LoadX/LoadY/Start appears. Define
//   SWITCH_SEQUENCER_TIMEOUT_EN to exercise the watchdog path.
// -----------------------------------------------------------------------------
module tb_switch_sequencer;
    import switch_sequencer_pkg::*;

    localparam int DB   = 4;
    localparam int TOUT = 100;

    localparam logic [2:0] K_LOADX = 3'b100;
    localparam logic [2:0] K_LOADY = 3'b010;
    localparam logic [2:0] K_START = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] op;
    } strobe_t;

    logic       clk;
    logic       rst;
    logic [7:0] pc;

    int n_checks;
    int n_errors;

    strobe_t exp_q[$];
    strobe_t mon_e;

    switch_sequencer_if #(.n(8), .SW_W(10)) bus ();

    assign bus.Halted = (pc == HALT_PC);

    switch_sequencer #(
        .n             (8),
        .SW_W          (10),
        .GO_BIT        (8),
        .DB_CYCLES     (DB),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] outs;
    assign outs = {bus.Operand, bus.LoadX, bus.LoadY, bus.Start, bus.ShowSel,
                   bus.Busy, bus.Error, bus.DbSwitches};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Drive the control switch plus operand bits, then wait until the FSM's
    // registered response to the debounced edge is visible.
    task automatic go_drive(input logic go, input logic [7:0] low);
        bus.Switches = {1'b0, go, low};
        cyc(3 + DB);
    endtask

    task automatic expect_strobe(input logic [2:0] kind, input logic [7:0] op);
        strobe_t e;
        e.kind = kind;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.LoadX || bus.LoadY || bus.Start)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 32'({bus.LoadX, bus.LoadY, bus.Start}), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("strobe_kind", 32'({bus.LoadX, bus.LoadY, bus.Start}), 32'(mon_e.kind));
                check_eq("strobe_operand", 32'(bus.Operand), 32'(mon_e.op));
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        pc           = 8'h00;
        bus.Switches = '0;

        // Reset held 1000 ns with switches toggling.
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            bus.Switches = 10'($urandom);
            if (i % 25 == 24) check_eq("reset_outs", 32'(outs), 32'(0));
        end

        // Debounce latency after release.
        bus.Switches = 10'h2A5;
        rst = 1'b0;
        cyc(1 + DB);
        check_eq("db_latency_early", 32'(bus.DbSwitches), 32'(0));
        cyc(1);
        check_eq("db_latency", 32'(bus.DbSwitches), 32'(10'h2A5));

        // Control-switch glitch of DB-1 clocks is dropped.
        bus.Switches = 10'h3A5;
        cyc(DB - 1);
        bus.Switches = 10'h2A5;
        cyc(DB + 4);
        check_eq("glitch_db", 32'(bus.DbSwitches), 32'(10'h2A5));

        // Halted in IDLE ignored.
        bus.Switches = 10'h010;
        cyc(DB + 3);
        check_eq("db_x", 32'(bus.DbSwitches), 32'(10'h010));
        pc = HALT_PC;
        cyc(3);
        pc = 8'h00;
        cyc(1);
        check_eq("idle_halt_ignored", 32'({bus.Busy, bus.ShowSel, bus.Operand}), 32'(0));

        // Load X.
        expect_strobe(K_LOADX, 8'h10);
        go_drive(1'b1, 8'h10);
        check_eq("loadx", 32'({bus.LoadX, bus.Operand}), 32'({1'b1, 8'h10}));
        cyc(1);
        check_eq("loadx_one_cycle", 32'(bus.LoadX), 32'(0));

        // Halted and fall in X_LOADED ignored.
        pc = HALT_PC;
        cyc(3);
        pc = 8'h00;
        go_drive(1'b0, 8'h2A);
        cyc(1);
        check_eq("x_hold", 32'({bus.Operand, bus.Busy}), 32'({8'h10, 1'b0}));

        // Load Y.
        expect_strobe(K_LOADY, 8'h2A);
        go_drive(1'b1, 8'h2A);
        check_eq("loady", 32'({bus.LoadY, bus.Operand}), 32'({1'b1, 8'h2A}));

        // Start one cycle after the debounced fall.
        expect_strobe(K_START, 8'h2A);
        bus.Switches = 10'h02A;
        cyc(2 + DB);
        check_eq("start_not_yet", 32'({bus.Start, bus.DbSwitches[8]}), 32'(0));
        cyc(1);
        check_eq("start", 32'({bus.Start, bus.Busy}), 32'(2'b11));
        cyc(1);
        check_eq("start_one_cycle", 32'({bus.Start, bus.Busy}), 32'(2'b01));

        // Edges in RUN ignored.
        go_drive(1'b1, 8'h2A);
        go_drive(1'b0, 8'h2A);
        check_eq("run_edges_ignored", 32'({bus.Busy, bus.ShowSel}), 32'(2'b10));

        // Halt, show X, show Y, back to idle.
        pc = HALT_PC;
        cyc(1);
        check_eq("halt_show_x", 32'({bus.Busy, bus.ShowSel}), 32'(0));
        pc = 8'h00;
        go_drive(1'b1, 8'h2A);
        check_eq("show_y", 32'(bus.ShowSel), 32'(1));
        go_drive(1'b0, 8'h2A);
        check_eq("show_done", 32'(bus.ShowSel), 32'(0));

        // Halted already high on the first RUN cycle: one-cycle RUN.
        expect_strobe(K_LOADX, 8'h33);
        go_drive(1'b1, 8'h33);
        check_eq("idle_after_show", 32'({bus.LoadX, bus.Operand}), 32'({1'b1, 8'h33}));
        go_drive(1'b0, 8'h44);
        expect_strobe(K_LOADY, 8'h44);
        go_drive(1'b1, 8'h44);
        pc = HALT_PC;
        expect_strobe(K_START, 8'h44);
        go_drive(1'b0, 8'h44);
        check_eq("min_run_start", 32'({bus.Start, bus.Busy}), 32'(2'b11));
        cyc(1);
        check_eq("min_run_end", 32'({bus.Busy, bus.ShowSel}), 32'(0));
        pc = 8'h00;
        go_drive(1'b1, 8'h44);
        go_drive(1'b0, 8'h44);

        // Reset in the cycle the Y_LOADED fall is seen: Start dropped.
        expect_strobe(K_LOADX, 8'h55);
        go_drive(1'b1, 8'h55);
        go_drive(1'b0, 8'h55);
        expect_strobe(K_LOADY, 8'h55);
        go_drive(1'b1, 8'h55);
        bus.Switches = 10'h055;
        cyc(2 + DB);
        check_eq("abort_fall_seen", 32'({bus.DbSwitches[8], bus.Start}), 32'(0));
        rst = 1'b1;
        cyc(2);
        check_eq("abort_reset_outs", 32'(outs), 32'(0));
        rst = 1'b0;
        cyc(DB + 4);
        check_eq("abort_after", 32'({bus.Start, bus.Busy, bus.Operand}), 32'(0));

        // Fresh sequence into RUN without Halted.
        expect_strobe(K_LOADX, 8'h66);
        go_drive(1'b1, 8'h66);
        check_eq("abort_idle", 32'({bus.LoadX, bus.Operand}), 32'({1'b1, 8'h66}));
        go_drive(1'b0, 8'h77);
        expect_strobe(K_LOADY, 8'h77);
        go_drive(1'b1, 8'h77);
        expect_strobe(K_START, 8'h77);
        go_drive(1'b0, 8'h77);
        check_eq("run2_start", 32'({bus.Start, bus.Busy}), 32'(2'b11));

`ifdef SWITCH_SEQUENCER_TIMEOUT_EN
        cyc(TOUT - 1);
        check_eq("timeout_early", 32'({bus.Error, bus.Busy}), 32'(2'b01));
        cyc(1);
        check_eq("timeout", 32'({bus.Error, bus.Busy}), 32'(2'b10));
        go_drive(1'b1, 8'h77);
        check_eq("error_after_rise", 32'(bus.Error), 32'(1));
        go_drive(1'b0, 8'h77);
        check_eq("error_cleared", 32'({bus.Error, bus.Busy}), 32'(0));
`else
        cyc(TOUT + 50);
        check_eq("no_timeout", 32'({bus.Error, bus.Busy}), 32'(2'b01));
        pc = HALT_PC;
        cyc(1);
        check_eq("late_halt", 32'({bus.Error, bus.Busy}), 32'(0));
        pc = 8'h00;
        go_drive(1'b1, 8'h77);
        go_drive(1'b0, 8'h77);
`endif

        expect_strobe(K_LOADX, 8'h88);
        go_drive(1'b1, 8'h88);
        check_eq("final_idle", 32'({bus.LoadX, bus.Operand}), 32'({1'b1, 8'h88}));
        cyc(2);
        check_eq("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switch_sequencer.md
Name: switch_sequencer

Overview:
- Synthesisable front-end between board switches and the parametrised cpu.
- Synchronises and debounces all switch inputs, detects edges on a control switch, and runs the operand-load handshake: load X, load Y, go, show result, show Y, restart.
- Issues single-cycle strobes and a latched operand to the cpu, and waits for the cpu halt indication.

Parameters:
- n, 8: operand/datapath width; must satisfy n <= GO_BIT.
- SW_W, 10: number of switch inputs.
- GO_BIT, 8: index of the control (load/go/show) switch.
- DB_CYCLES, 16: consecutive stable cycles required to accept a switch change; minimum 1.
- TIMEOUT_CYCLES, 65535: RUN watchdog limit; used only with TIMEOUT_EN.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Switches  in  SW_W  raw asynchronous switch levels.
- Halted  in  1  cpu has finished (Pc reached 8'hFF); level.
- Operand  out  n  latched debounced Switches[n-1:0].
- LoadX  out  1  one-cycle strobe: Operand is X.
- LoadY  out  1  one-cycle strobe: Operand is Y.
- Start  out  1  one-cycle strobe: begin execution.
- ShowSel  out  1  0 = display result/X, 1 = display Y.
- Busy  out  1  high in RUN.
- Error  out  1  watchdog expired (TIMEOUT_EN only; otherwise tied 0).
- DbSwitches  out  SW_W  debounced switch levels.

Behaviour:
- Reset (async, active high): all outputs 0, all sync/debounce registers 0, counters 0, FSM in IDLE.
- Input path: 2-flop synchroniser per bit. A per-bit counter increments while the synced value differs from DbSwitches[i], and clears when they match. When the counter reaches DB_CYCLES, DbSwitches[i] toggles and the counter clears.
  - Latency from raw change to DbSwitches: 2 + DB_CYCLES clocks.
  - A glitch shorter than DB_CYCLES is never propagated.
- Edge detect: go_q is DbSwitches[GO_BIT] registered. rise = db & ~go_q; fall = ~db & go_q. Both are valid for exactly one cycle.
- FSM states: IDLE, X_LOADED, Y_LOADED, RUN, SHOW_X, SHOW_Y (plus ERROR with TIMEOUT_EN).
  - IDLE on rise: Operand <= DbSwitches[n-1:0]; LoadX=1 next cycle; go to X_LOADED.
  - X_LOADED: fall is ignored. On rise: Operand latched; LoadY=1 next cycle; go to Y_LOADED.
  - Y_LOADED on fall: Start=1 next cycle; go to RUN.
  - RUN: Busy=1. When Halted is sampled 1, go to SHOW_X with ShowSel=0. Edges in RUN are ignored.
  - SHOW_X on rise: go to SHOW_Y, ShowSel=1.
  - SHOW_Y on fall: go to IDLE, ShowSel=0.
- All strobes are registered, high for exactly 1 cycle, and mutually exclusive.
- Operand holds its value except in the load cycles.
- Halted outside RUN is ignored. Halted already high on the first RUN cycle is accepted immediately, so the minimum RUN duration is 1 cycle.
- Reset mid-sequence aborts: any pending strobe is dropped, and the FSM returns to IDLE.
- Debounce counter width is clog2(DB_CYCLES+1); it never wraps.

Optional Feature:
- Macro: SWITCH_SEQUENCER_TIMEOUT_EN.
- Defined: a RUN-cycle counter clears on entry to RUN. When it reaches TIMEOUT_CYCLES without Halted:
  - FSM goes to ERROR; Error=1 and Busy=0.
  - ERROR exits to IDLE only on a rise followed by a fall of the go switch; Error clears on the exit.
  - If Halted and timeout occur in the same cycle, Halted wins.
- Undefined: no counter and no ERROR state; Error is tied 0; RUN waits indefinitely.

Decomposition:
- Package switch_sequencer_pkg holds:
  - state enum typedef seq_state_t;
  - default constants for DB_CYCLES and GO_BIT;
  - cpu halt address constant 8'hFF, for benches.
- One sub-module, switch_debounce: a single-bit synchroniser plus debounce counter, parametrised by DB_CYCLES. It is instantiated SW_W times in a generate loop.

Test Plan:
- Reset held 1000 ns with Switches toggling -> all outputs 0, FSM IDLE; after release, DbSwitches follows within 2+DB_CYCLES clocks.
- GO_BIT pulse of DB_CYCLES-1 clocks -> no DbSwitches change, no LoadX.
- Full sequence with DB_CYCLES=4 and Switches[7:0] = 8'h10 for X, then 8'h2A for Y:
  - LoadX with Operand=8'h10;
  - LoadY with Operand=8'h2A;
  - Start 1 cycle after the debounced fall, Busy=1;
  - Halted -> ShowSel=0; rise -> ShowSel=1; fall -> IDLE.
- Halted pulsed while in IDLE or X_LOADED -> ignored; FSM and outputs unchanged.
- Reset asserted one cycle after Y_LOADED fall -> Start never observed, FSM IDLE, Operand=0.
- With SWITCH_SEQUENCER_TIMEOUT_EN and TIMEOUT_CYCLES=100, Halted never asserted -> Error=1 exactly 100 cycles after Start; go-switch rise then fall -> Error=0, IDLE.
